// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Holds the arbiter state enum and a $clog2-based width function.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  // Width of a counter/index able to hold values 0..n-1 (never 0 bits).
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Rotating-priority picker: first set bit of req at or after ptr.
// Ports: req_i vector, ptr_i start index; found_o any hit, idx_o winner.
module rr_picker #(
  parameter int n = 4,
  parameter int w = 2
) (
  input  logic [n-1:0] req_i,
  input  logic [w-1:0] ptr_i,
  output logic         found_o,
  output logic [w-1:0] idx_o
);

  int c;

  // Modulo wrap keeps non-power-of-2 requester counts correct.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    c       = 0;
    for (int k = 0; k < n; k++) begin
      c = (int'(ptr_i) + k) % n;
      if (!found_o && req_i[c]) begin
        found_o = 1'b1;
        idx_o   = w'(c);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among num_req streams.
// Ports: clk/rst, req_valid/req_data/req_ready, wdata/winc/wfull, grant_id, busy.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int datawidth = 8,
  parameter int num_req   = 4,
  parameter int max_burst = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [num_req-1:0]           req_valid,
  input  logic [num_req*datawidth-1:0] req_data,
  output logic [num_req-1:0]           req_ready,
  output logic [datawidth-1:0]         wdata,
  output logic                         winc,
  input  logic                         wfull,
  output logic [$clog2(num_req)-1:0]   grant_id,
  output logic                         busy
);

  localparam int GW = cw(num_req);
  localparam int CW = cw(max_burst + 1);

  state_e        state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          g_valid;
  logic          last;
  logic          rel;
  logic [GW-1:0] next_ptr;
  logic [GW-1:0] pick_ptr;
  logic          found;
  logic [GW-1:0] idx;

  assign busy     = (state_q == GRANT);
  assign grant_id = grant_q;
  assign g_valid  = req_valid[grant_q];
  assign winc     = busy & g_valid & ~wfull;
  assign last     = (cnt_q == CW'(max_burst - 1));
  assign rel      = busy & ((winc & last) | ~g_valid);

  assign next_ptr = (grant_q == GW'(num_req - 1)) ? '0
                                                  : grant_q + 1'b1;

  // On release, re-arbitrate this cycle from the advanced pointer so the
  // outgoing grantee is considered last and no idle bubble appears.
  assign pick_ptr = rel ? next_ptr : rr_ptr_q;

  assign req_ready = (busy & ~wfull) ? (num_req'(1) << grant_q) : '0;

  always_comb begin
    wdata = '0;
    for (int i = 0; i < num_req; i++) begin
      if (grant_q == GW'(i)) begin
        wdata = req_data[i*datawidth +: datawidth];
      end
    end
  end

  rr_picker #(
    .n (num_req),
    .w (GW)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (pick_ptr),
    .found_o (found),
    .idx_o   (idx)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (winc) cnt_d = cnt_q + 1'b1;
        if (rel) begin
          rr_ptr_d = next_ptr;
          cnt_d    = '0;
          if (found) grant_d = idx;
          else       state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized and directed bench for fifo_write_arbiter.
// Compares every output each cycle against a queue-free behavioural model.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   wdata;
  logic            winc;
  logic            wfull = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;

  fifo_write_arbiter #(
    .datawidth (DW),
    .num_req   (N),
    .max_burst (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wdata     (wdata),
    .winc      (winc),
    .wfull     (wfull),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int wincs  = 0;

  // model: owner = current grantee (-1 none), taken = words in this burst
  int owner = -1;
  int gid   = 0;
  int ptr   = 0;
  int taken = 0;

  logic [DW-1:0] wd [N];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic step(input logic [N-1:0] v,
                      input logic wf,
                      input logic r);
    logic [N-1:0] exp_rdy;
    logic         exp_winc;
    int           w;
    @(posedge clk);
    #1;
    rst       = r;
    wfull     = wf;
    req_valid = v;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = wd[i];
    #1;
    exp_rdy  = '0;
    exp_winc = 1'b0;
    if (owner >= 0) begin
      if (!wf) exp_rdy[owner] = 1'b1;
      exp_winc = v[owner] && !wf;
    end
    check("busy", 32'(busy), 32'(owner >= 0));
    check("grant_id", 32'(grant_id), 32'(gid));
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("winc", 32'(winc), 32'(exp_winc));
    if (exp_winc) check("wdata", 32'(wdata), 32'(wd[owner]));
    if (winc) wincs++;
    if (exp_winc) wd[owner] = wd[owner] + 1'b1;
    if (r) begin
      owner = -1;
      gid   = 0;
      ptr   = 0;
      taken = 0;
    end else if (owner < 0) begin
      w = pick(v, ptr);
      if (w >= 0) begin
        owner = w;
        gid   = w;
        taken = 0;
      end
    end else begin
      if (exp_winc) taken++;
      if ((exp_winc && taken == MB) || !v[owner]) begin
        ptr   = (owner + 1) % N;
        w     = pick(v, ptr);
        owner = w;
        if (w >= 0) gid = w;
        taken = 0;
      end
    end
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    step(v, 1'b0, 1'b1);
    step(v, 1'b0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) wd[i] = DW'(i * 16);

    // reset with all valid, then continuous demand from everyone
    do_reset(4'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    step(4'hF, 1'b0, 1'b0);
    wincs = 0;
    for (int c = 0; c < 20; c++) step(4'hF, 1'b0, 1'b0);
    check("throughput", 32'(wincs), 32'd20);

    // single requester keeps the port with no gaps
    do_reset(4'h0);
    step(4'h2, 1'b0, 1'b0);
    wincs = 0;
    for (int c = 0; c < 12; c++) step(4'h2, 1'b0, 1'b0);
    check("single_stream", 32'(wincs), 32'd12);

    // backpressure in the middle of req0's burst
    do_reset(4'h0);
    step(4'h3, 1'b0, 1'b0);
    step(4'h3, 1'b0, 1'b0);
    step(4'h3, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step(4'h3, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) step(4'h3, 1'b0, 1'b0);

    // early drop by req2 hands over to req3 then req0
    do_reset(4'h0);
    for (int c = 0; c < 3; c++) step(4'h4, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++) step(4'h9, 1'b0, 1'b0);
    check("drop_grant", 32'(grant_id), 32'd0);

    // reset in the middle of req1's burst
    do_reset(4'h0);
    for (int c = 0; c < 6; c++) step(4'hF, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b1);
    step(4'hF, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b0);
    check("post_rst_grant", 32'(grant_id), 32'd0);

    // randomized traffic, backpressure and occasional reset
    for (int c = 0; c < 4000; c++) begin
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 9) < 7);
      step(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write-port arbiter that shares the write side of one FIFO between `num_req` requesters in the write clock domain. Each requester has a valid/ready stream. The arbiter grants one requester at a time for a burst of up to `max_burst` words, and drives the FIFO `wdata`/`winc`. It honours `wfull` backpressure, so no word is ever written into a full FIFO or lost.

## Interface
Parameters:
- `datawidth`, 8, width of one data word.
- `num_req`, 4, number of requesters (≥2).
- `max_burst`, 4, maximum words per grant (≥1).

Ports:
- `clk`  in  1  write-domain clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `num_req`  per-requester word valid.
- `req_data`  in  `num_req*datawidth`  requester i's word at bits [i*datawidth +: datawidth].
- `req_ready`  out  `num_req`  per-requester accept; one-hot or zero.
- `wdata`  out  `datawidth`  word to FIFO write port.
- `winc`  out  1  FIFO write strobe.
- `wfull`  in  1  FIFO full flag (write domain).
- `grant_id`  out  `$clog2(num_req)`  index of current grantee.
- `busy`  out  1  high while in GRANT.

## Operation
- **Handshake:** a word transfers on a cycle where `req_valid[i]` and `req_ready[i]` are both high. The requester holds `req_data` stable while valid is high and ready is low.
- **States: IDLE, GRANT.**
  - **IDLE:** `req_ready` = 0, `winc` = 0.
    - If any `req_valid` is high, pick the first valid index at or after `rr_ptr` (rotating priority, wrapping at `num_req`).
    - Register `grant_id` = winner, clear `burst_cnt`, go to GRANT.
  - **GRANT, with g = `grant_id`:**
    - `req_ready[g]` = ~`wfull`; all other ready bits are 0.
    - `winc` = `req_valid[g]` & ~`wfull`.
    - `wdata` = `req_data[g]` (combinational mux; `wdata` is don't-care when `winc` = 0).
- **Burst counting:** `burst_cnt` increments on every `winc`.
- **Release** happens when either:
  - `winc` is high and `burst_cnt` == `max_burst`-1 (the last word is written that cycle), or
  - `req_valid[g]` is low, with no transfer that cycle.
- **On release:**
  - `rr_ptr` = (g+1) mod `num_req`.
  - Arbitration is evaluated in the same cycle using the updated pointer, and it excludes no one. The requester just released, if still valid, is eligible only if no other requester is valid.
  - Next state is GRANT with the new winner, or IDLE if no requester is valid.
  - Result: no bubble between back-to-back bursts.
- **`wfull` high during GRANT:**
  - Stall: `winc` = 0, `req_ready` = 0.
  - `burst_cnt` holds and the grant is held; there is no timeout.
  - If `req_valid[g]` drops while full, the grant is still released.
- **`max_burst` = 1:** every word releases.
- **Counter widths:**
  - `burst_cnt` is `$clog2(max_burst+1)` bits.
  - `rr_ptr` is `$clog2(num_req)` bits.
  - The wrap compares against `num_req`-1, so non-power-of-2 counts are handled.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `grant_id` 0, `burst_cnt` 0, `busy` 0. Consequently `winc` 0, `req_ready` 0.
- **`rst` mid-burst:** at the next edge, all state returns to reset values, and the partial burst is abandoned. Words already written stay in the FIFO.
- **Arbitration latency from IDLE:** valid seen in cycle t, then the grant is registered at the edge ending t. The first `winc` is possible in cycle t+1.
- **Burst-to-burst:** the first word of the next burst is in the cycle after the last word of the current burst.
- Peak throughput is 1 word/cycle under continuous demand.
- `winc` and `req_ready` depend combinationally on `wfull` and `req_valid[g]`. All state is registered.
- **`wfull` timing:** `wfull` is assumed registered by the FIFO. A write in cycle t that fills the FIFO yields `wfull` = 1 in t+1, and the arbiter suppresses `winc` from t+1.

## Structure
- **Package `fifo_arb_pkg`:**
  - state enum (IDLE, GRANT);
  - helper function for `$clog2`-based widths (`grant_id`, `burst_cnt`).
- **Sub-module `rr_picker`:** combinational.
  - Inputs: `req` vector, `ptr`.
  - Outputs: `found`, `idx`.
  - Used by both IDLE arbitration and release re-arbitration.
- **Top:** state/counter registers, data mux, ready/winc decode.

## Test plan
Parameters: `num_req` = 4, `max_burst` = 4, `datawidth` = 8.
1. **Reset:** `rst` = 1 for 2 cycles with all valids high → `winc` = 0, `req_ready` = 0000, `busy` = 0, `grant_id` = 0. Release `rst` → req0 granted, first `winc` one cycle later with `wdata` = `req_data[0]`.
2. **Single requester:** req1 continuously valid with data 0x10, 0x11, … → continuous `winc` with no gaps; `grant_id` stays 1; `burst_cnt` wraps every 4 words; data in order 0x10…0x1B over 12 cycles.
3. **All four continuously valid:** `grant_id` sequence 0,1,2,3,0; exactly 4 `winc` per grant; 20 words in 20 cycles after the first grant.
4. **Backpressure:** `wfull` = 1 for 3 cycles after the 2nd word of req0's burst → `winc` = 0 and `req_ready` = 0000 for those cycles; `grant_id` stays 0; words 3 and 4 follow once `wfull` = 0; then req1 is granted.
5. **Early drop:** req2 drops valid after 2 words while req3 and req0 are valid → release with no transfer that cycle; next grant is 3; after req3's burst, next grant is 0.
6. **Reset mid-burst:** `rst` after req1's 2nd word, all valid → next cycle `winc` = 0 and `busy` = 0; after reset, first grant is 0, not 2.
